// File: rtl/osc_pkg.sv
// Shared codes for the time-multiplexed oscillator bank: waveform select,
// configuration register map and sweep FSM states.
package osc_pkg;

  typedef enum logic [1:0] {
    SAW   = 2'd0,
    TRI   = 2'd1,
    PULSE = 2'd2,
    SUB   = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    CFG_INC   = 2'd0,
    CFG_CTRL  = 2'd1,
    CFG_PW    = 2'd2,
    CFG_PHASE = 2'd3
  } cfg_addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CFG_DATA_W = 16;

  // Control word layout: [1:0] waveform, [2] hard-sync enable.
  function automatic wave_t ctrl_wave(input logic [CFG_DATA_W-1:0] data);
    return wave_t'(data[1:0]);
  endfunction

  function automatic logic ctrl_sync(input logic [CFG_DATA_W-1:0] data);
    return data[2];
  endfunction

endpackage

// File: rtl/osc_wave.sv
// Combinational waveform shaper: turns one voice's accumulator, sub-oscillator
// bit, waveform select and pulse width into an unsigned output sample.
module osc_wave
  import osc_pkg::*;
#(
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6
) (
  input  logic [BITDEPTH+BITFRACTION-1:0] acc,
  input  logic                            sub,
  input  wave_t                           wave,
  input  logic [BITDEPTH-1:0]             pw,
  output logic [BITDEPTH-1:0]             sample
);

  localparam int ACCW   = BITDEPTH + BITFRACTION;
  localparam int TOPBIT = ACCW - 1;

  logic [BITDEPTH-1:0] phase;
  logic [BITDEPTH-1:0] tri_base;
  logic [BITDEPTH-1:0] tri_val;
  logic [BITDEPTH-1:0] pulse_val;
  logic                acc_unused;

  assign phase      = acc[TOPBIT -: BITDEPTH];
  // Triangle folds the lower half-period: one bit finer than the saw phase.
  assign tri_base   = acc[TOPBIT-1 -: BITDEPTH];
  assign tri_val    = acc[TOPBIT] ? ~tri_base : tri_base;
  assign pulse_val  = (phase < pw) ? '1 : '0;
  assign acc_unused = ^acc;

  always_comb begin
    sample = phase;
    case (wave)
      SAW:     sample = phase;
      TRI:     sample = tri_val;
      PULSE:   sample = pulse_val;
      SUB:     sample = sub ? pulse_val : ~pulse_val;
      default: sample = phase;
    endcase
  end

endmodule

// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one shared accumulator datapath visits
// every voice in ascending order once per sample_tick, one voice per clock.
module osc_bank
  import osc_pkg::*;
#(
  parameter int VOICES      = 4,
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6,
  parameter int INCWIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [$clog2(VOICES)-1:0]  cfg_voice,
  input  logic [1:0]                 cfg_addr,
  input  logic [15:0]                cfg_wdata,
  output logic                       busy,
  output logic                       out_valid,
  output logic [$clog2(VOICES)-1:0]  out_voice,
  output logic [BITDEPTH-1:0]        out_sample,
  output logic                       overrun
);

  localparam int VW   = $clog2(VOICES);
  localparam int ACCW = BITDEPTH + BITFRACTION;

  localparam logic [BITDEPTH-1:0] SAMPLE_RST = {1'b0, {(BITDEPTH-1){1'b1}}};
  localparam logic [BITDEPTH-1:0] PW_RST     = BITDEPTH'(2 ** (BITDEPTH - 4));

  // Sweep control
  state_t          state_reg, state_next;
  logic [VW-1:0]   voice_reg, voice_next;
  logic            run;
  logic            last_voice;

  assign run        = (state_reg == ST_RUN);
  assign last_voice = (voice_reg == VW'(VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      voice_reg <= '0;
    end else begin
      state_reg <= state_next;
      voice_reg <= voice_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    voice_next = voice_reg;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (sample_tick) begin
          state_next = ST_RUN;
          voice_next = '0;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_voice) begin
          state_next = ST_IDLE;
          voice_next = '0;
        end else begin
          voice_next = voice_reg + VW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        voice_next = '0;
      end
    endcase
  end

  // Per-voice state, flattened for the shared datapath mux
  logic [ACCW-1:0]     acc_arr   [VOICES];
  logic [INCWIDTH-1:0] inc_arr   [VOICES];
  wave_t               wave_arr  [VOICES];
  logic [BITDEPTH-1:0] pw_arr    [VOICES];
  logic [VOICES-1:0]   sub_arr;
  logic [VOICES-1:0]   sync_arr;
  logic [VOICES-1:0]   wrapped_arr;
  logic [VOICES-1:0]   wrapped_prev;

  // Shared datapath for the voice selected by voice_reg
  logic [ACCW-1:0]     cur_acc;
  logic [INCWIDTH-1:0] cur_inc;
  wave_t               cur_wave;
  logic [BITDEPTH-1:0] cur_pw;
  logic                cur_sub;
  logic [ACCW:0]       sum;
  logic                wrap;
  logic                sync_hit;
  logic [ACCW-1:0]     acc_upd;
  logic                sub_upd;
  logic                wrapped_upd;
  logic [BITDEPTH-1:0] cur_sample;

  assign cur_acc  = acc_arr[voice_reg];
  assign cur_inc  = inc_arr[voice_reg];
  assign cur_wave = wave_arr[voice_reg];
  assign cur_pw   = pw_arr[voice_reg];
  assign cur_sub  = sub_arr[voice_reg];

  assign sum  = {1'b0, cur_acc} + (ACCW + 1)'(cur_inc);
  assign wrap = sum[ACCW];

  // The previous voice was always processed one cycle earlier in this sweep,
  // so its wrapped flag already reflects the current sweep.
  assign sync_hit    = sync_arr[voice_reg] & wrapped_prev[voice_reg];
  assign acc_upd     = sync_hit ? '0 : sum[ACCW-1:0];
  assign sub_upd     = sync_hit ? cur_sub : (cur_sub ^ wrap);
  assign wrapped_upd = sync_hit | wrap;

  osc_wave #(
    .BITDEPTH    (BITDEPTH),
    .BITFRACTION (BITFRACTION)
  ) u_wave (
    .acc    (cur_acc),
    .sub    (cur_sub),
    .wave   (cur_wave),
    .pw     (cur_pw),
    .sample (cur_sample)
  );

  // Config data zero-extended so any INCWIDTH/BITDEPTH up to 32 slices cleanly
  logic [31:0] wdata_ext;
  logic        wdata_unused;

  assign wdata_ext    = {16'd0, cfg_wdata};
  assign wdata_unused = ^wdata_ext;

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice
      logic [ACCW-1:0]     acc_reg;
      logic [INCWIDTH-1:0] inc_reg;
      wave_t               wave_reg;
      logic [BITDEPTH-1:0] pw_reg;
      logic                sub_reg;
      logic                sync_reg;
      logic                wrapped_reg;
      logic                proc_hit;
      logic                cfg_hit;

      assign proc_hit = run && (voice_reg == VW'(gi));
      assign cfg_hit  = cfg_we && (cfg_voice == VW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg     <= '0;
          inc_reg     <= '0;
          wave_reg    <= SAW;
          pw_reg      <= PW_RST;
          sub_reg     <= 1'b0;
          sync_reg    <= 1'b0;
          wrapped_reg <= 1'b0;
        end else begin
          if (proc_hit) begin
            acc_reg     <= acc_upd;
            sub_reg     <= sub_upd;
            wrapped_reg <= wrapped_upd;
          end
          // Placed after the datapath update so a coinciding phase reset wins
          if (cfg_hit) begin
            case (cfg_addr_t'(cfg_addr))
              CFG_INC:   inc_reg <= wdata_ext[INCWIDTH-1:0];
              CFG_CTRL: begin
                wave_reg <= ctrl_wave(cfg_wdata);
                sync_reg <= ctrl_sync(cfg_wdata);
              end
              CFG_PW:    pw_reg <= wdata_ext[BITDEPTH-1:0];
              CFG_PHASE: begin
                acc_reg <= '0;
                sub_reg <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      assign acc_arr[gi]     = acc_reg;
      assign inc_arr[gi]     = inc_reg;
      assign wave_arr[gi]    = wave_reg;
      assign pw_arr[gi]      = pw_reg;
      assign sub_arr[gi]     = sub_reg;
      assign sync_arr[gi]    = sync_reg;
      assign wrapped_arr[gi] = wrapped_reg;

      // Voice 0 has no predecessor, which makes its sync_en inert
      if (gi == 0) begin : g_first
        assign wrapped_prev[gi] = 1'b0;
      end else begin : g_rest
        assign wrapped_prev[gi] = wrapped_arr[gi-1];
      end
    end
  endgenerate

  // Output stream and sticky overrun
  logic                out_valid_reg;
  logic [VW-1:0]       out_voice_reg;
  logic [BITDEPTH-1:0] out_sample_reg;
  logic                overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_voice_reg  <= '0;
      out_sample_reg <= SAMPLE_RST;
      overrun_reg    <= 1'b0;
    end else begin
      out_valid_reg <= run;
      if (run) begin
        out_voice_reg  <= voice_reg;
        out_sample_reg <= cur_sample;
      end
      if (sample_tick && run) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_voice  = out_voice_reg;
  assign out_sample = out_sample_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_osc_bank.sv
// Directed bench for osc_bank: an arithmetic voice model predicts every
// streamed sample, plus hand-computed literals for the key waveform points.
module tb_osc_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        busy;
  logic        out_valid;
  logic [1:0]  out_voice;
  logic [13:0] out_sample;
  logic        overrun;

  osc_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_voice   (cfg_voice),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_voice   (out_voice),
    .out_sample  (out_sample),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: accumulator is a 20-bit phase, sample is 14 bits
  int m_acc [4];
  int m_sub [4];
  int m_wr  [4];
  int m_inc [4];
  int m_wave[4];
  int m_sync[4];
  int m_pw  [4];
  int exp_v[$];
  int exp_s[$];
  int hold_exp = 'h1FFF;
  int got[4];
  int valid_cnt = 0;
  bit check_en = 1'b0;
  int ev, es;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int shape(input int acc, input int sub, input int wave, input int pw);
    int p, half, pulse;
    p     = acc / 64;
    half  = (acc / 32) % 16384;
    pulse = (p < pw) ? 'h3FFF : 0;
    case (wave)
      0:       return p;
      1:       return (acc >= 'h80000) ? ('h3FFF - half) : half;
      2:       return pulse;
      default: return sub ? pulse : ('h3FFF - pulse);
    endcase
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_acc[v] = 0; m_sub[v] = 0; m_wr[v] = 0; m_inc[v] = 0;
      m_wave[v] = 0; m_sync[v] = 0; m_pw[v] = 'h400;
    end
  endtask

  task automatic model_sweep();
    int sum;
    for (int v = 0; v < 4; v++) begin
      exp_v.push_back(v);
      exp_s.push_back(shape(m_acc[v], m_sub[v], m_wave[v], m_pw[v]));
      sum = m_acc[v] + m_inc[v];
      if (m_sync[v] != 0 && v > 0 && m_wr[v-1] != 0) begin
        m_acc[v] = 0;
        m_wr[v]  = 1;
      end else begin
        m_acc[v] = sum % 'h100000;
        m_wr[v]  = (sum >= 'h100000) ? 1 : 0;
        if (m_wr[v] != 0) m_sub[v] = 1 - m_sub[v];
      end
    end
  endtask

  task automatic model_cfg(input int v, input int a, input int d);
    case (a)
      0: m_inc[v] = d;
      1: begin m_wave[v] = d % 4; m_sync[v] = (d / 4) % 2; end
      2: m_pw[v] = d % 16384;
      default: begin m_acc[v] = 0; m_sub[v] = 0; end
    endcase
  endtask

  task automatic cfg_write(input int v, input int a, input int d);
    cfg_we    = 1'b1;
    cfg_voice = v[1:0];
    cfg_addr  = a[1:0];
    cfg_wdata = d[15:0];
    model_cfg(v, a, d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      model_sweep();
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (7) @(negedge clk);
    end
  endtask

  // Sweep whose phase-reset write lands on the edge that processes voice pv
  task automatic sweep_with_phase_reset(input int pv);
    sample_tick = 1'b1;
    model_sweep();
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (pv) @(negedge clk);
    cfg_write(pv, 3, 0);
    repeat (6 - pv) @(negedge clk);
  endtask

  // Compare process: every streamed sample against the model, holds otherwise
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      if (out_valid) begin
        valid_cnt++;
        if (exp_v.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got voice %0d, required no output", out_voice);
        end else begin
          ev = exp_v.pop_front();
          es = exp_s.pop_front();
          check("out_voice", 32'(out_voice), ev);
          check($sformatf("sample_v%0d", ev), 32'(out_sample), es);
          got[out_voice] = int'(out_sample);
          hold_exp = es;
        end
      end else begin
        check("sample_hold", 32'(out_sample), hold_exp);
      end
    end
  end

  int cnt0;

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
    cfg_voice = '0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sample", 32'(out_sample), 'h1FFF);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // Saw on voice 0, triangle on voice 3
    cfg_write(0, 1, 0);
    cfg_write(0, 0, 'h4000);
    cfg_write(3, 1, 1);
    cfg_write(3, 0, 'h6000);
    sweep(1);  check("saw_s0", got[0], 'h000);
    sweep(1);  check("saw_s1", got[0], 'h100); check("tri_s1", got[3], 'h300);
    sweep(1);  check("saw_s2", got[0], 'h200);
    sweep(20); check("tri_s22", got[3], 'h3DFF);
    sweep(41); check("saw_s63", got[0], 'h3F00);
    sweep(1);  check("saw_s64_wrap", got[0], 'h000);

    // Pulse on voice 1
    cfg_write(1, 1, 2);
    cfg_write(1, 2, 'h1000);
    cfg_write(1, 0, 'h4000);
    sweep(1);  check("pulse_s0", got[1], 'h3FFF);
    sweep(15); check("pulse_s15", got[1], 'h3FFF);
    sweep(1);  check("pulse_s16", got[1], 'h0000);
    sweep(47); check("pulse_s63", got[1], 'h0000);
    sweep(1);  check("pulse_s64", got[1], 'h3FFF);

    // Hard sync: voice 1 follows voice 0 wraps
    cfg_write(0, 3, 0);
    cfg_write(1, 3, 0);
    cfg_write(0, 0, 'h8000);
    cfg_write(1, 1, 4);
    cfg_write(1, 0, 'h3000);
    sweep(1);  check("sync_s0", got[1], 'h0);
    sweep(31); check("sync_s31", got[1], 'h1740);
    sweep(1);  check("sync_s32", got[1], 'h0);
    sweep(1);  check("sync_s33", got[1], 'hC0);
    sweep(31); check("sync_s64", got[1], 'h0);

    // Sub-oscillator on voice 2, then phase reset coinciding with its slot
    cfg_write(2, 3, 0);
    cfg_write(2, 1, 3);
    cfg_write(2, 0, 'h8000);
    cfg_write(2, 2, 'h1000);
    sweep(1);  check("sub_s0", got[2], 'h0);
    sweep(8);  check("sub_s8", got[2], 'h3FFF);
    sweep(24); check("sub_s32", got[2], 'h3FFF);
    sweep(1);
    sweep_with_phase_reset(2);
    check("sub_preupdate", got[2], 'h3FFF);
    sweep(1);  check("sub_after_preset", got[2], 'h0);
    sweep(1);  check("sub_after_preset2", got[2], 'h0);

    // Tick 3 cycles after the first: ignored, overrun set, 4 valid cycles
    cnt0 = valid_cnt;
    sample_tick = 1'b1;
    model_sweep();
    @(negedge clk);
    sample_tick = 1'b0;
    check("busy_rise", 32'(busy), 1);
    repeat (2) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    check("busy_fall", 32'(busy), 0);
    check("overrun_set", 32'(overrun), 1);
    repeat (5) @(negedge clk);
    check("valid_cycles", valid_cnt - cnt0, 4);
    sweep(1);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset asserted while voice 2 is being processed
    sample_tick = 1'b1;
    model_sweep();
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_v.delete();
    exp_s.delete();
    model_reset();
    hold_exp = 'h1FFF;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sample", 32'(out_sample), 'h1FFF);
    check("midrst_overrun", 32'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) got[v] = -1;
    repeat (3) @(negedge clk);
    sweep(1);
    for (int v = 0; v < 4; v++) check($sformatf("postrst_acc_v%0d", v), got[v], 0);

    check("queue_drained", exp_v.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
